argmax_classify: RTL

Downstream consumer of the inference tile's output layer. On the tile's one-cycle `done` pulse it captures the `OUTPUT_SZ` activation words, scans them sequentially for the maximum, and presents the winning class index and its score to the host-side logic. The result is held under a valid/ready handshake. The block is the last stage between the tile and the result readout path.

---
 rtl/tile_pkg.sv | 20 ++
 rtl/max_cmp.sv | 24 ++
 rtl/argmax_classify.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the inference tile and its output-side consumers.
//   state_t      : argmax_classify controller states
//   TILE_*       : default output-layer geometry shared with the tile
//   idx_w(n)     : index width for n classes, never narrower than one bit
package tile_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_HOLD
    } state_t;

    localparam int TILE_OUTPUT_SZ = 10;
    localparam int TILE_DATA_W    = 32;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_cmp.sv
// Signed strict-greater compare-and-select for the running maximum.
//   best_score_i / best_idx_i : current running best
//   candidate_i / cand_idx_i  : activation under test and its index
//   sel_score_o / sel_idx_o   : updated running best
// Strict greater-than keeps the earlier (lower) index on a tie.
module max_cmp #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic [DATA_W-1:0] best_score_i,
    input  logic [IDX_W-1:0]  best_idx_i,
    input  logic [DATA_W-1:0] candidate_i,
    input  logic [IDX_W-1:0]  cand_idx_i,
    output logic [DATA_W-1:0] sel_score_o,
    output logic [IDX_W-1:0]  sel_idx_o
);

    logic replace;

    assign replace     = $signed(candidate_i) > $signed(best_score_i);
    assign sel_score_o = replace ? candidate_i : best_score_i;
    assign sel_idx_o   = replace ? cand_idx_i  : best_idx_i;

endmodule

// File: rtl/argmax_classify.sv
// Captures the tile's output-layer activations on a done pulse, scans them
// one per cycle for the signed maximum and holds the winning index/score
// under a valid/ready handshake.
//   clk, rst     : clock, synchronous active-high reset
//   done, result : capture strobe and activation vector from the tile
//   ready        : downstream accepts the held classification
//   valid        : class_idx/class_score are valid and stable
//   class_idx    : index of the maximum activation (lowest index on a tie)
//   class_score  : value of the maximum activation
//   busy         : scanning or holding a result
//   overrun      : one-cycle pulse, cycle after a dropped done
//
// state  | meaning
// S_IDLE | waiting for done
// S_SCAN | comparing res_q[scan_idx_q] against the running best
// S_HOLD | result presented, waiting for ready
module argmax_classify
    import tile_pkg::*;
#(
    parameter int OUTPUT_SZ = TILE_OUTPUT_SZ,
    parameter int DATA_W    = TILE_DATA_W,
    parameter int IDX_W     = idx_w(OUTPUT_SZ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               done,
    input  logic [OUTPUT_SZ-1:0][DATA_W-1:0]   result,
    input  logic                               ready,
    output logic                               valid,
    output logic [IDX_W-1:0]                   class_idx,
    output logic [DATA_W-1:0]                  class_score,
    output logic                               busy,
    output logic                               overrun
);

    localparam logic [IDX_W:0] SCAN_FIRST = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] SCAN_STEP  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] SCAN_LAST  = (IDX_W+1)'(OUTPUT_SZ-1);

    state_t                           state_q, state_d;
    logic [OUTPUT_SZ-1:0][DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0]                best_score_q, best_score_d;
    logic [IDX_W-1:0]                 best_idx_q, best_idx_d;
    logic [IDX_W:0]                   scan_idx_q, scan_idx_d;
    logic                             overrun_q, overrun_d;

    logic                             capture;
    logic [DATA_W-1:0]                cand;
    logic [DATA_W-1:0]                cmp_score;
    logic [IDX_W-1:0]                 cmp_idx;

    // A new vector is only taken when nothing is pending: idle, or the held
    // result is being accepted in the same cycle.
    assign capture = done && ((state_q == S_IDLE) || ((state_q == S_HOLD) && ready));

    // Explicit mux keeps the wider scan counter from ever addressing past
    // the last element.
    always_comb begin
        cand = '0;
        for (int i = 0; i < OUTPUT_SZ; i++) begin
            if (scan_idx_q == (IDX_W+1)'(i)) begin
                cand = res_q[i];
            end
        end
    end

    max_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_max_cmp (
        .best_score_i (best_score_q),
        .best_idx_i   (best_idx_q),
        .candidate_i  (cand),
        .cand_idx_i   (scan_idx_q[IDX_W-1:0]),
        .sel_score_o  (cmp_score),
        .sel_idx_o    (cmp_idx)
    );

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        scan_idx_d   = scan_idx_q;
        overrun_d    = done && !capture && (state_q != S_IDLE);

        case (state_q)
            S_SCAN: begin
                best_score_d = cmp_score;
                best_idx_d   = cmp_idx;
                scan_idx_d   = scan_idx_q + SCAN_STEP;
                if (scan_idx_q == SCAN_LAST) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Capture overrides the above so a done accepted alongside ready
        // goes straight into the next scan.
        if (capture) begin
            res_d        = result;
            best_score_d = result[0];
            best_idx_d   = '0;
            scan_idx_d   = SCAN_FIRST;
            state_d      = (OUTPUT_SZ == 1) ? S_HOLD : S_SCAN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            res_q        <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            scan_idx_q   <= SCAN_FIRST;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            scan_idx_q   <= scan_idx_d;
            overrun_q    <= overrun_d;
        end
    end

    assign valid       = (state_q == S_HOLD);
    assign busy        = (state_q != S_IDLE);
    assign class_idx   = best_idx_q;
    assign class_score = best_score_q;
    assign overrun     = overrun_q;

endmodule
